mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory-side request port between the CPU's instruction-fetch and data-access requesters. Sits between the pipeline's fetch and memory stages and the cache/bus interface. Holds at most one transaction in flight and returns a one-cycle `*_data_ok` pulse to the owning requester. The pipeline's hazard logic holds each requester's `*_valid` high, and stalls, until that pulse.

## Interface
- `ROUND_ROBIN`, default 0: 0 = data side always wins a tie; 1 = a tie goes to the side not granted last.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `i_valid`  in  1  instruction fetch request pending; held until `i_data_ok`.
- `i_addr`  in  32  fetch address; word read, strobe ignored.
- `i_data_ok`  out  1  one-cycle pulse; `i_data` valid this cycle.
- `i_data`  out  32  fetched word.
- `d_valid`  in  1  data request pending; held until `d_data_ok`.
- `d_addr`  in  32  data address.
- `d_size`  in  2  0 = byte, 1 = half, 2 = word.
- `d_strobe`  in  4  byte write enables; all zero = read.
- `d_wdata`  in  32  write data.
- `d_data_ok`  out  1  one-cycle pulse; `d_data` valid this cycle.
- `d_data`  out  32  read data; undefined for writes.
- `m_req_valid`  out  1  memory request valid.
- `m_req_ready`  in  1  memory accepts the request this cycle.
- `m_addr`, `m_size`, `m_strobe`, `m_wdata`  out  32/2/4/32  registered copy of the granted request; `m_strobe` = 0 for fetches.
- `m_resp_valid`  in  1  response for the in-flight request.
- `m_rdata`  in  32  response data.

## Operation
- FSM states are `IDLE`, `REQ`, `WAIT` and `RESP`.
- **IDLE**
  - Arbitrate among `i_valid` and `d_valid`. With both pending: D wins if `ROUND_ROBIN`=0; otherwise the side not equal to `last_grant` wins.
  - On grant, latch address, size, strobe, wdata and owner (I/D) into the request register, update `last_grant`, and go to `REQ`.
  - With no request, stay in `IDLE`.
- **REQ**
  - `m_req_valid`=1 and the request fields are held stable.
  - `m_req_ready`=1 → go to `WAIT`; otherwise stay.
  - `m_resp_valid` is ignored in this state.
- **WAIT**
  - `m_resp_valid`=1 → latch `m_rdata` into the response register and go to `RESP`.
- **RESP**
  - Assert the owner's `*_data_ok` for exactly one cycle, with `*_data` driven from the response register. Next state is `IDLE`.
  - The requester still shows `valid`=1 in this cycle. It is not re-arbitrated, because arbitration happens only in `IDLE`.
- A request arriving during `REQ`/`WAIT`/`RESP` waits; its `valid` stays high.
- `i_data` and `d_data` both drive the response register; only the `*_data_ok` pulse distinguishes the owner.
- Reset (`resetn`=0 at an edge):
  - state → `IDLE`; `last_grant` → I (so the first tie with `ROUND_ROBIN`=1 goes to D); request and response registers → 0.
  - All outputs then read 0: `m_req_valid`, `i_data_ok`, `d_data_ok`, `i_data`, `d_data`, `m_addr`, `m_size`, `m_strobe`, `m_wdata`.
  - Reset in the middle of an operation abandons the transaction. A late `m_resp_valid` arriving in `IDLE` or `REQ` is ignored.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Fastest transaction:
  - cycle 0: `IDLE` with `valid` high.
  - cycle 1: `REQ`; ready is high.
  - cycle 2: `WAIT`; response is valid.
  - cycle 3: `RESP`, `data_ok`=1.
  - cycle 4: `IDLE`, where the next arbitration happens.
- Minimum spacing between grants is therefore 4 cycles.
- Back-to-back D requests with `i_valid` high and `ROUND_ROBIN`=0 may starve I. This is acceptable because a D miss stalls fetch anyway.

## Structure
- Put `arb_state_e` (`IDLE`/`REQ`/`WAIT`/`RESP`) and `arb_owner_e` (I/D) in the shared mycpu package next to the existing control typedefs.
- Size encoding constants live alongside the existing bus request types.
- Sub-module `mem_arbiter_select`: combinational, with inputs `i_valid`, `d_valid`, `last_grant` and `ROUND_ROBIN`, and outputs grant and owner.

## Test plan
- **Single fetch.** Stimulus: reset, then `i_valid`=1, `i_addr`=0xBFC00000; `m_req_ready`=1 immediately; `m_resp_valid` with `m_rdata`=0x24080001 one cycle later. Required: `m_req_valid` seen in cycle 1, `m_strobe`=0, `i_data_ok` in cycle 3 with `i_data`=0x24080001.
- **Tie, D priority.** Stimulus: `ROUND_ROBIN`=0; both valid in the same cycle, D is a store with strobe 0xF and data 0xDEADBEEF. Required: D is served first and `d_data_ok` pulses once; I is granted at the next `IDLE`.
- **Round-robin tie.** Stimulus: `ROUND_ROBIN`=1; both valid held for 4 transactions. Required: grant order D, I, D, I.
- **Slow slave.** Stimulus: `m_req_ready` low for 5 cycles, then response after 3 more. Required: `m_addr`, `m_size`, `m_strobe` and `m_wdata` stable throughout; exactly one `data_ok`.
- **Reset during `WAIT`.** Stimulus: reset asserted in `WAIT`, then `m_resp_valid` arrives the cycle after reset is released. Required: all outputs 0 and no `data_ok`.
- **Byte load.** Stimulus: `d_size`=0, `d_strobe`=0, `d_addr`=0x80000003. Required: `m_size`=0, `m_strobe`=0, `m_addr`=0x80000003 passed through unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state, request owner,
// access-size encodings and the packed request payload carried to memory.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  // Access size encodings used on d_size / m_size
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

  // Request payload as presented on the memory side
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Instruction fetches are always full-word reads
  function automatic mem_req_t fetch_req(input logic [ADDR_W-1:0] addr);
    mem_req_t r;
    r.addr   = addr;
    r.size   = SIZE_WORD;
    r.strobe = '0;
    r.wdata  = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_select.sv
// Grant selection between the fetch (I) and data (D) requesters.
// Ports:
//   i_valid, d_valid : pending requests
//   last_grant       : owner of the previous grant (1 = D)
//   grant            : some request can be granted
//   owner            : chosen side (1 = D)
module mem_arbiter_select
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic i_valid,
  input  logic d_valid,
  input  logic last_grant,
  output logic grant,
  output logic owner
);

  // A tie goes to D in fixed-priority mode, else to the side not granted last
  always_comb begin
    grant = i_valid | d_valid;
    owner = OWNER_I;
    if (d_valid && !i_valid) begin
      owner = OWNER_D;
    end else if (d_valid && i_valid) begin
      if (ROUND_ROBIN == 0) begin
        owner = OWNER_D;
      end else begin
        owner = (last_grant == OWNER_D) ? OWNER_I : OWNER_D;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between instruction fetch and data access.
// One transaction in flight; the owner gets a one-cycle *_data_ok pulse.
// Ports:
//   clk, resetn                      : clock, synchronous active-low reset
//   i_valid/i_addr                   : fetch request (held until i_data_ok)
//   i_data_ok/i_data                 : fetch completion pulse and word
//   d_valid/d_addr/d_size/d_strobe/d_wdata : data request (held until d_data_ok)
//   d_data_ok/d_data                 : data completion pulse and read data
//   m_req_valid/m_req_ready          : memory request handshake
//   m_addr/m_size/m_strobe/m_wdata   : registered granted request
//   m_resp_valid/m_rdata             : memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_data_ok,
  output logic [31:0] d_data,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_addr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_resp_valid,
  input  logic [31:0] m_rdata
);

  arb_state_e  state_q;
  arb_owner_e  owner_q;
  arb_owner_e  last_grant_q;
  mem_req_t    req_q;
  logic [31:0] resp_q;

  mem_req_t    i_req;
  mem_req_t    d_req;
  logic        sel_grant;
  logic        sel_owner;
  logic        last_grant_d;

  assign i_req        = fetch_req(i_addr);
  assign d_req        = '{addr: d_addr, size: d_size, strobe: d_strobe, wdata: d_wdata};
  assign last_grant_d = (last_grant_q == OWNER_D);

  mem_arbiter_select #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_select (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_grant (last_grant_d),
    .grant      (sel_grant),
    .owner      (sel_owner)
  );

  // Arbitration FSM; every output below is a flop or a flop-held register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_I;
      req_q        <= '0;
      resp_q       <= '0;
      m_req_valid  <= 1'b0;
      i_data_ok    <= 1'b0;
      d_data_ok    <= 1'b0;
    end else begin
      i_data_ok <= 1'b0;
      d_data_ok <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_grant) begin
            req_q        <= sel_owner ? d_req : i_req;
            owner_q      <= arb_owner_e'(sel_owner);
            last_grant_q <= arb_owner_e'(sel_owner);
            m_req_valid  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          // Responses are not expected before acceptance and are dropped here
          if (m_req_ready) begin
            m_req_valid <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (m_resp_valid) begin
            resp_q  <= m_rdata;
            state_q <= RESP;
            if (owner_q == OWNER_D) begin
              d_data_ok <= 1'b1;
            end else begin
              i_data_ok <= 1'b1;
            end
          end
        end
        RESP: begin
          // data_ok is high for this single cycle; requester drops valid after
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_addr   = req_q.addr;
  assign m_size   = req_q.size;
  assign m_strobe = req_q.strobe;
  assign m_wdata  = req_q.wdata;

  // Both data outputs show the response register; data_ok tells the owner
  assign i_data = resp_q;
  assign d_data = resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance per arbitration mode.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  // Contents of the modelled memory
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A0F_C3E1;
  endfunction

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL rr%0d %s: got 0x%08h, expected 0x%08h", inst, name, act, req);
    end
  endtask

  task automatic flag(input int inst, input string name);
    tests++;
    fails++;
    $display("FAIL rr%0d %s", inst, name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    logic        resetn;
    logic        i_valid, i_data_ok, d_valid, d_data_ok;
    logic [31:0] i_addr, i_data, d_addr, d_wdata, d_data;
    logic [1:0]  d_size, m_size;
    logic [3:0]  d_strobe, m_strobe;
    logic        m_req_valid, m_req_ready, m_resp_valid;
    logic [31:0] m_addr, m_wdata, m_rdata;

    exp_t        sbq[$];
    bit          done, manual, free, last_d, ok_i_seen, ok_d_seen, busy;
    int          cnt, wait_cnt, p_i, p_d, p_ready, max_dly, spur;
    logic [31:0] cap_addr;

    mem_arbiter #(.ROUND_ROBIN(g)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .i_valid      (i_valid),
      .i_addr       (i_addr),
      .i_data_ok    (i_data_ok),
      .i_data       (i_data),
      .d_valid      (d_valid),
      .d_addr       (d_addr),
      .d_size       (d_size),
      .d_strobe     (d_strobe),
      .d_wdata      (d_wdata),
      .d_data_ok    (d_data_ok),
      .d_data       (d_data),
      .m_req_valid  (m_req_valid),
      .m_req_ready  (m_req_ready),
      .m_addr       (m_addr),
      .m_size       (m_size),
      .m_strobe     (m_strobe),
      .m_wdata      (m_wdata),
      .m_resp_valid (m_resp_valid),
      .m_rdata      (m_rdata)
    );

    // One clock of stimulus: requesters, reference arbitration, memory slave
    task automatic step();
      exp_t e;
      bit   pick_d;
      @(posedge clk);
      #1;
      if (!manual) begin
        if (ok_i_seen) begin i_valid = 1'b0; free = 1'b1; end
        if (ok_d_seen) begin d_valid = 1'b0; free = 1'b1; end
        if (!i_valid && $urandom_range(99) < p_i) begin
          i_valid = 1'b1;
          i_addr  = $urandom() & 32'hFFFF_FFFC;
        end
        if (!d_valid && $urandom_range(99) < p_d) begin
          d_valid  = 1'b1;
          d_addr   = $urandom();
          d_size   = 2'($urandom_range(2));
          d_strobe = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
          d_wdata  = $urandom();
        end
        // Arbiter is free: pick by priority rule and expect that transaction
        if (free && (i_valid || d_valid)) begin
          pick_d = d_valid && (!i_valid || (g == 0) || !last_d);
          if (pick_d) begin
            e = '{1'b1, d_addr, d_size, d_strobe, d_wdata, mem_word(d_addr)};
          end else begin
            e = '{1'b0, i_addr, SIZE_WORD, 4'h0, 32'h0, mem_word(i_addr)};
          end
          sbq.push_back(e);
          last_d = pick_d;
          free   = 1'b0;
        end
        m_resp_valid = 1'b0;
        m_rdata      = 32'h0;
        m_req_ready  = 1'b0;
        if (busy) begin
          if (cnt == 0) begin
            m_resp_valid = 1'b1;
            m_rdata      = mem_word(cap_addr);
            busy         = 1'b0;
          end else begin
            cnt--;
          end
        end else if (m_req_valid) begin
          if ($urandom_range(99) < p_ready) begin
            m_req_ready = 1'b1;
            busy        = 1'b1;
            cap_addr    = m_addr;
            cnt         = $urandom_range(max_dly);
          end else if (spur != 0 && $urandom_range(3) == 0) begin
            m_resp_valid = 1'b1;
            m_rdata      = $urandom();
          end
        end
      end
      ok_i_seen = i_data_ok;
      ok_d_seen = d_data_ok;
    endtask

    task automatic check_zero(input string tag);
      chk(g, {tag, " m_req_valid"}, 32'(m_req_valid), 32'd0);
      chk(g, {tag, " i_data_ok"},   32'(i_data_ok),   32'd0);
      chk(g, {tag, " d_data_ok"},   32'(d_data_ok),   32'd0);
      chk(g, {tag, " i_data"},      i_data,           32'd0);
      chk(g, {tag, " d_data"},      d_data,           32'd0);
      chk(g, {tag, " m_addr"},      m_addr,           32'd0);
      chk(g, {tag, " m_size"},      32'(m_size),      32'd0);
      chk(g, {tag, " m_strobe"},    32'(m_strobe),    32'd0);
      chk(g, {tag, " m_wdata"},     m_wdata,          32'd0);
    endtask

    task automatic run_random(input int n);
      manual = 1'b0;
      for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain();
      int k;
      p_i = 0;
      p_d = 0;
      k = 0;
      while ((sbq.size() != 0 || i_valid || d_valid || busy) && k < 500) begin
        step();
        k++;
      end
      if (k >= 500) flag(g, "drain did not complete");
    endtask

    // Monitor: compare memory-side request and completions with the queue head
    always @(negedge clk) begin : mon
      exp_t e;
      if (resetn) begin
        if (m_req_valid) begin
          if (sbq.size() == 0) begin
            flag(g, "m_req_valid with no granted request");
          end else begin
            chk(g, "m_addr",   m_addr,          sbq[0].addr);
            chk(g, "m_size",   32'(m_size),     32'(sbq[0].size));
            chk(g, "m_strobe", 32'(m_strobe),   32'(sbq[0].strobe));
            if (sbq[0].is_d) chk(g, "m_wdata", m_wdata, sbq[0].wdata);
          end
        end
        if (i_data_ok || d_data_ok) begin
          wait_cnt = 0;
          if (sbq.size() == 0) begin
            flag(g, "data_ok with nothing in flight");
          end else begin
            e = sbq.pop_front();
            chk(g, "data_ok owner {i,d}", 32'({i_data_ok, d_data_ok}), e.is_d ? 32'd1 : 32'd2);
            if (!e.is_d) chk(g, "i_data", i_data, e.rdata);
            else if (e.strobe == 4'h0) chk(g, "d_data", d_data, e.rdata);
          end
        end else if (sbq.size() != 0) begin
          wait_cnt++;
          if (wait_cnt > 400) begin
            flag(g, "timeout waiting for data_ok");
            sbq.delete();
            wait_cnt = 0;
          end
        end
      end
    end

    initial begin
      done = 1'b0; manual = 1'b1; free = 1'b1; last_d = 1'b0; busy = 1'b0;
      ok_i_seen = 1'b0; ok_d_seen = 1'b0; cnt = 0; wait_cnt = 0; cap_addr = '0;
      p_i = 0; p_d = 0; p_ready = 100; max_dly = 0; spur = 0;
      resetn = 1'b0; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
      d_size = '0; d_strobe = '0; d_wdata = '0; m_req_ready = 1'b0;
      m_resp_valid = 1'b0; m_rdata = '0;
      step();
      step();
      resetn = 1'b1;
      step();
      check_zero("reset");

      // Fastest fetch: REQ in cycle 1, response in cycle 2, data_ok in cycle 3
      i_valid = 1'b1; i_addr = 32'hBFC0_0000; m_req_ready = 1'b1;
      sbq.push_back('{1'b0, 32'hBFC0_0000, SIZE_WORD, 4'h0, 32'h0, 32'h2408_0001});
      last_d = 1'b0; free = 1'b0;
      step();
      chk(g, "fetch m_req_valid cycle1", 32'(m_req_valid), 32'd1);
      step();
      chk(g, "fetch m_req_valid cycle2", 32'(m_req_valid), 32'd0);
      m_req_ready = 1'b0; m_resp_valid = 1'b1; m_rdata = 32'h2408_0001;
      step();
      chk(g, "fetch i_data_ok cycle3", 32'(i_data_ok), 32'd1);
      m_resp_valid = 1'b0; m_rdata = 32'h0;
      step();
      chk(g, "fetch i_data_ok cycle4", 32'(i_data_ok), 32'd0);
      i_valid = 1'b0; free = 1'b1;

      // General traffic with spurious responses during REQ
      p_i = 40; p_d = 40; p_ready = 70; max_dly = 3; spur = 1;
      run_random(1500);
      // Both sides always pending: every grant is a tie
      p_i = 100; p_d = 100; p_ready = 100; max_dly = 0; spur = 0;
      run_random(200);
      // Slow slave: long ready stalls and response delays
      p_i = 50; p_d = 50; p_ready = 15; max_dly = 5; spur = 1;
      run_random(600);
      drain();

      // Byte load, then reset while it waits in WAIT
      manual = 1'b1; m_resp_valid = 1'b0; m_req_ready = 1'b0;
      d_valid = 1'b1; d_addr = 32'h8000_0003; d_size = SIZE_BYTE; d_strobe = 4'h0; d_wdata = 32'h0000_0011;
      sbq.push_back('{1'b1, 32'h8000_0003, SIZE_BYTE, 4'h0, 32'h0000_0011, 32'h0});
      step();
      chk(g, "byte m_req_valid", 32'(m_req_valid), 32'd1);
      m_req_ready = 1'b1;
      step();
      chk(g, "byte in WAIT m_req_valid", 32'(m_req_valid), 32'd0);
      m_req_ready = 1'b0; resetn = 1'b0; d_valid = 1'b0;
      sbq.delete(); wait_cnt = 0; free = 1'b1; last_d = 1'b0; busy = 1'b0;
      step();
      resetn = 1'b1; m_resp_valid = 1'b1; m_rdata = 32'hFFFF_FFFF;
      step();
      check_zero("after reset in WAIT");
      m_resp_valid = 1'b1;
      step();
      check_zero("late response ignored");
      m_resp_valid = 1'b0; m_rdata = 32'h0;
      step();
      check_zero("idle after reset");
      ok_i_seen = 1'b0; ok_d_seen = 1'b0;

      // Ties right after reset check the reset value of the last-grant memory
      p_i = 100; p_d = 100; p_ready = 100; max_dly = 0; spur = 0;
      run_random(60);
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int c;
    c = 0;
    while (!(h[0].done && h[1].done) && c < 20000) begin
      @(posedge clk);
      c++;
    end
    if (!(h[0].done && h[1].done)) flag(-1, "bench did not finish in time");
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
